// File: rtl/ps2_move_rx.sv
// rtl/ps2_move_rx.sv - PS/2 Set-2 receiver that turns make codes into cube move strobes
module ps2_move_rx #(
    parameter int TIMEOUT_CYCLES = 200000
) (
    input  logic       clk,
    input  logic       btn_reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] scan_code,
    output logic       code_valid,
    output logic       frame_err,
    output logic       key_cw,
    output logic       key_ccw,
    output logic       key_hrot,
    output logic       key_vrot,
    output logic       key_reset
);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    state_t      state, state_n;
    logic        clk_s1, clk_s2, clk_prev, dat_s1, dat_s2;
    logic        fall, bit_q;
    logic [2:0]  cnt, cnt_n;
    logic [7:0]  shift, shift_n;
    logic        par, par_n;
    logic [17:0] tcnt, tcnt_n;
    logic        brk, brk_n, ext, ext_n;
    logic [7:0]  scan_n;
    logic        valid_n, err_n;
    logic [4:0]  keys, keys_n;

    // Sample bit is registered alongside the edge so both line up in the same cycle.
    always_ff @(posedge clk or posedge btn_reset) begin
        if (btn_reset) begin
            clk_s1   <= 1'b1;
            clk_s2   <= 1'b1;
            clk_prev <= 1'b1;
            dat_s1   <= 1'b1;
            dat_s2   <= 1'b1;
            fall     <= 1'b0;
            bit_q    <= 1'b1;
        end else begin
            clk_s1   <= ps2_clk;
            clk_s2   <= clk_s1;
            clk_prev <= clk_s2;
            dat_s1   <= ps2_data;
            dat_s2   <= dat_s1;
            fall     <= clk_prev & ~clk_s2;
            bit_q    <= dat_s2;
        end
    end

    always_ff @(posedge clk or posedge btn_reset) begin
        if (btn_reset) begin
            state      <= IDLE;
            cnt        <= 3'd0;
            shift      <= 8'h00;
            par        <= 1'b0;
            tcnt       <= 18'd0;
            brk        <= 1'b0;
            ext        <= 1'b0;
            scan_code  <= 8'h00;
            code_valid <= 1'b0;
            frame_err  <= 1'b0;
            keys       <= 5'd0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            shift      <= shift_n;
            par        <= par_n;
            tcnt       <= tcnt_n;
            brk        <= brk_n;
            ext        <= ext_n;
            scan_code  <= scan_n;
            code_valid <= valid_n;
            frame_err  <= err_n;
            keys       <= keys_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        shift_n = shift;
        par_n   = par;
        brk_n   = brk;
        ext_n   = ext;
        scan_n  = scan_code;
        valid_n = 1'b0;
        err_n   = 1'b0;
        keys_n  = 5'd0;
        tcnt_n  = (state == IDLE || fall) ? 18'd0 : tcnt + 18'd1;

        if (fall) begin
            case (state)
                IDLE: begin
                    if (!bit_q) begin
                        state_n = DATA;
                        cnt_n   = 3'd0;
                    end
                end
                DATA: begin
                    shift_n = {bit_q, shift[7:1]};
                    cnt_n   = cnt + 3'd1;
                    if (cnt == 3'd7) state_n = PARITY;
                end
                PARITY: begin
                    par_n   = bit_q;
                    state_n = STOP;
                end
                STOP: begin
                    state_n = IDLE;
                    if (bit_q && (^{shift, par})) begin
                        valid_n = 1'b1;
                        scan_n  = shift;
                        if (shift == 8'hF0) begin
                            brk_n = 1'b1;
                        end else if (shift == 8'hE0) begin
                            ext_n = 1'b1;
                        end else begin
                            // Break and extended prefixes suppress the following key.
                            if (!brk && !ext) begin
                                case (shift)
                                    8'h23:   keys_n = 5'b00001;
                                    8'h1C:   keys_n = 5'b00010;
                                    8'h1D:   keys_n = 5'b00100;
                                    8'h1B:   keys_n = 5'b01000;
                                    8'h2D:   keys_n = 5'b10000;
                                    default: keys_n = 5'b00000;
                                endcase
                            end
                            brk_n = 1'b0;
                            ext_n = 1'b0;
                        end
                    end else begin
                        err_n = 1'b1;
                        brk_n = 1'b0;
                        ext_n = 1'b0;
                    end
                end
                default: state_n = IDLE;
            endcase
        end else if (state != IDLE && tcnt == 18'(TIMEOUT_CYCLES - 1)) begin
            state_n = IDLE;
            err_n   = 1'b1;
            brk_n   = 1'b0;
            ext_n   = 1'b0;
            tcnt_n  = 18'd0;
        end
    end

    assign key_cw    = keys[0];
    assign key_ccw   = keys[1];
    assign key_hrot  = keys[2];
    assign key_vrot  = keys[3];
    assign key_reset = keys[4];

endmodule

// File: tb/tb_ps2_move_rx.sv
// tb/tb_ps2_move_rx.sv - scoreboard bench for ps2_move_rx
module tb_ps2_move_rx;

    localparam int TO   = 300;
    localparam int HALF = 10;

    logic       clk = 1'b0;
    logic       btn_reset;
    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] scan_code;
    logic       code_valid, frame_err;
    logic       key_cw, key_ccw, key_hrot, key_vrot, key_reset;

    ps2_move_rx #(.TIMEOUT_CYCLES(TO)) dut (
        .clk        (clk),
        .btn_reset  (btn_reset),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .scan_code  (scan_code),
        .code_valid (code_valid),
        .frame_err  (frame_err),
        .key_cw     (key_cw),
        .key_ccw    (key_ccw),
        .key_hrot   (key_hrot),
        .key_vrot   (key_vrot),
        .key_reset  (key_reset)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       err;
        logic [7:0] code;
        logic [4:0] keys;
        int         cyc;
    } ev_t;

    ev_t        sb[$];
    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    logic [7:0] last_good = 8'h00;

    always @(posedge clk) cyc <= cyc + 1;

    wire [4:0] keys_out = {key_reset, key_vrot, key_hrot, key_ccw, key_cw};

    always @(negedge clk) begin
        if (!btn_reset && (code_valid || frame_err || keys_out != 5'd0)) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL unexpected_strobe: err=%0d valid=%0d code=%h keys=%b cyc=%0d",
                         frame_err, code_valid, scan_code, keys_out, cyc);
            end else begin
                ev_t e;
                e = sb.pop_front();
                if (frame_err !== e.err || code_valid !== !e.err || scan_code !== e.code ||
                    keys_out !== e.keys || cyc != e.cyc) begin
                    bad++;
                    $display("FAIL event: got err=%0d valid=%0d code=%h keys=%b cyc=%0d want err=%0d valid=%0d code=%h keys=%b cyc=%0d",
                             frame_err, code_valid, scan_code, keys_out, cyc,
                             e.err, !e.err, e.code, e.keys, e.cyc);
                end
            end
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic err, input logic [7:0] code, input logic [4:0] k, input int at);
        ev_t e;
        e.err  = err;
        e.code = code;
        e.keys = k;
        e.cyc  = at;
        sb.push_back(e);
    endtask

    task automatic frame(input logic [7:0] b, input logic bp, input logic bs, input logic [4:0] k);
        logic [10:0] bits;
        bits = {~bs, (~^b) ^ bp, b, 1'b0};
        for (int i = 0; i < 11; i++) begin
            ps2_data = bits[i];
            wait_cyc(HALF);
            ps2_clk = 1'b0;
            if (i == 10) begin
                if (bp || bs) begin
                    push(1'b1, last_good, 5'd0, cyc + 4);
                end else begin
                    push(1'b0, b, k, cyc + 4);
                    last_good = b;
                end
            end
            wait_cyc(HALF);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        wait_cyc(30);
    endtask

    task automatic partial(input int nbits, input logic expect_timeout);
        logic [10:0] bits;
        bits = {1'b1, 1'b0, 8'h5A, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_data = bits[i];
            wait_cyc(HALF);
            ps2_clk = 1'b0;
            if (expect_timeout && i == nbits - 1) push(1'b1, last_good, 5'd0, cyc + TO + 4);
            wait_cyc(HALF);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
    endtask

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    initial begin
        btn_reset = 1'b1;
        ps2_clk   = 1'b1;
        ps2_data  = 1'b1;
        #1;
        check("reset_outputs", {scan_code, code_valid, frame_err, 1'b0, keys_out}, 16'h0000);
        wait_cyc(5);
        btn_reset = 1'b0;
        wait_cyc(10);

        frame(8'h23, 1'b0, 1'b0, 5'b00001);
        frame(8'hF0, 1'b0, 1'b0, 5'b00000);
        frame(8'h1C, 1'b0, 1'b0, 5'b00000);
        frame(8'h1C, 1'b0, 1'b0, 5'b00010);
        frame(8'hE0, 1'b0, 1'b0, 5'b00000);
        frame(8'h1D, 1'b0, 1'b0, 5'b00000);
        frame(8'h1B, 1'b0, 1'b0, 5'b01000);
        frame(8'h2D, 1'b1, 1'b0, 5'b00000);
        frame(8'h2D, 1'b0, 1'b1, 5'b00000);
        frame(8'h2D, 1'b0, 1'b0, 5'b10000);

        partial(5, 1'b1);
        wait_cyc(TO + 40);
        frame(8'h23, 1'b0, 1'b0, 5'b00001);

        frame(8'hF0, 1'b0, 1'b0, 5'b00000);
        partial(3, 1'b1);
        wait_cyc(TO + 40);
        frame(8'h1D, 1'b0, 1'b0, 5'b00100);

        frame(8'hF0, 1'b0, 1'b0, 5'b00000);
        frame(8'h1C, 1'b1, 1'b0, 5'b00000);
        frame(8'h1C, 1'b0, 1'b0, 5'b00010);

        frame(8'hE0, 1'b0, 1'b0, 5'b00000);
        frame(8'h23, 1'b0, 1'b0, 5'b00000);
        frame(8'h2D, 1'b0, 1'b0, 5'b10000);

        partial(6, 1'b0);
        btn_reset = 1'b1;
        #1;
        check("reset_midframe", {scan_code, code_valid, frame_err, 1'b0, keys_out}, 16'h0000);
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        last_good = 8'h00;
        wait_cyc(5);
        btn_reset = 1'b0;
        wait_cyc(10);
        frame(8'h1B, 1'b0, 1'b0, 5'b01000);

        ps2_data = 1'b1;
        ps2_clk  = 1'b0;
        wait_cyc(6);
        ps2_clk  = 1'b1;
        wait_cyc(TO + 40);
        frame(8'h1D, 1'b0, 1'b0, 5'b00100);

        wait_cyc(20);
        check("scoreboard_drained", 16'(sb.size()), 16'h0000);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

endmodule

// File: doc/ps2_move_rx.md
# ps2_move_rx

PS/2 keyboard receiver that gives the cube a keyboard as a second move source alongside the board buttons. It deserialises device-to-host PS/2 frames and checks framing and parity. It decodes Set-2 make codes into single-cycle move strobes with the same one-`clk`-cycle pulse semantics as the debounced button edges, so `logic_and_vga` can OR them into `is_cw_posedge`, `is_ccw_posedge`, `is_hrot_posedge` and `is_vrot_posedge`. It sits in `cube_top` between the PS/2 pins and `logic_and_vga`.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 200000: `clk` cycles with no PS/2 falling edge before a partial frame is abandoned (2 ms at 100 MHz).

Ports:
- `clk`, input, 1: system clock (100 MHz).
- `btn_reset`, input, 1: reset, asynchronous, active-high.
- `ps2_clk`, input, 1: PS/2 clock from the device, asynchronous, idle high.
- `ps2_data`, input, 1: PS/2 data from the device, asynchronous, idle high.
- `scan_code`, output, 8: last byte received with good parity and stop bit.
- `code_valid`, output, 1: one-cycle strobe; `scan_code` updated this cycle.
- `frame_err`, output, 1: one-cycle strobe on parity error, stop error or timeout.
- `key_cw`, output, 1: one-cycle strobe for make code 0x23 ('D').
- `key_ccw`, output, 1: one-cycle strobe for make code 0x1C ('A').
- `key_hrot`, output, 1: one-cycle strobe for make code 0x1D ('W').
- `key_vrot`, output, 1: one-cycle strobe for make code 0x1B ('S').
- `key_reset`, output, 1: one-cycle strobe for make code 0x2D ('R').

## Operation
- **Synchronisation:** `ps2_clk` and `ps2_data` each pass through a 2-FF synchroniser. A falling edge is detected as synced-previous=1 and synced-current=0. All bits are sampled from synced `ps2_data` on the detected edge.
- **Frame format:** 11 bits: start (0), D0..D7 LSB first, odd parity, stop (1).
- **FSM states:**
  - `IDLE`: on edge, if data=0 go to `DATA` and clear the bit counter. If data=1 (false start), stay in `IDLE` with no strobe.
  - `DATA`: shift data in, 8 edges, 3-bit counter, then go to `PARITY`.
  - `PARITY`: latch the parity bit, go to `STOP`.
  - `STOP`: on edge, the frame is good if stop=1 and XOR(D7..D0, parity)=1. Otherwise it is an error. Always return to `IDLE`.
- **Timeout:** an 18-bit counter clears on every falling edge and increments otherwise while the FSM is not `IDLE`. At `TIMEOUT_CYCLES` it pulses `frame_err`, forces `IDLE`, and clears the break/extended flags.
- **Good frame:** `scan_code` <= byte and `code_valid` pulses, for every good byte including 0xF0 and 0xE0.
- **Decode of a good byte:**
  - 0xF0 sets `brk`; 0xE0 sets `ext`. Neither produces a key strobe.
  - Any other byte: if `brk`=0 and `ext`=0 and it is in the map, pulse the matching `key_*`. Then clear `brk` and `ext`. Extended and break codes never produce a key strobe.
- **Error frame:** pulse `frame_err`. No `code_valid`, `scan_code` is unchanged, and `brk`/`ext` are cleared.
- **Typematic repeat:** repeated make codes each produce a strobe, which is intended.
- **Reset:** any state, including mid-frame, returns to `IDLE`. All outputs go to 0, `scan_code`=0x00, flags and counters are cleared, and synchroniser flops are set to 1. The first complete frame after release is accepted.

## Timing
- **Edge detection:** an edge is detected 3 `clk` cycles after the `ps2_clk` pin falls (2 sync stages plus edge register).
- **Strobes:** `code_valid`, `frame_err` and `key_*` assert exactly one cycle, in the cycle after the stop-bit edge is detected. `key_*` is coincident with `code_valid`.
- **Exclusivity:** at most one `key_*` is high in any cycle. `code_valid` and `frame_err` are never high together.
- **Minimum spacing:** two strobes are at least one full frame apart (about 11 PS/2 bit periods, at least 660 µs).
- **Timeout edge case:** if the timeout and an edge occur in the same cycle, the edge wins, the counter clears, and there is no error.
- **Latency:** no backpressure. The consumer samples the strobe on the single cycle it is high.

## Test plan
- **Good make code:** frame 0x23 with parity 0 at a 40 µs PS/2 half-period -> one `code_valid`, `scan_code`=0x23, one `key_cw` pulse in the same cycle, no `frame_err`.
- **Break sequence:** frames 0xF0 then 0x1C -> two `code_valid` pulses (0xF0, then 0x1C), no `key_ccw`. A following 0x1C -> one `key_ccw`.
- **Extended code:** frames 0xE0 then 0x1D -> two `code_valid` pulses, no `key_hrot`. Then 0x1B -> one `key_vrot`.
- **Bad parity and stop bit:** 0x2D with parity 0 -> one `frame_err`, no `code_valid`, no `key_reset`, `scan_code` unchanged. 0x2D with stop bit 0 -> the same result. 0x2D correct -> `key_reset`.
- **Timeout:** start bit plus 4 data bits, then `ps2_clk` held high for 2.5 ms -> `frame_err` at 200000 cycles after the last edge, FSM back in `IDLE`. The next full 0x23 frame -> `key_cw`.
- **Reset mid-frame:** assert `btn_reset` after 6 bits of a frame -> all outputs 0 immediately and `scan_code`=0x00. Release and send 0x1B -> `key_vrot`. Glitch low on `ps2_clk` with data=1 in `IDLE` -> no strobe.
